// File: rtl/fpu_round_pack.sv
// rtl/fpu_round_pack.sv - IEEE-754 single-precision rounding and packing pipeline
//
// Purpose: takes an unrounded float {sign, exp, frac, G, R, S} from the
// integer-to-float converter, applies the rounding mode and packs a 32-bit
// single-precision result with inexact and overflow flags. Two-stage
// valid/ready pipeline that carries a ROB tag and supports a same-cycle flush.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   flush                  kill all in-flight operations
//   in_valid/in_ready      input handshake
//   in_data[34:0]          {sign, exp[7:0], frac[22:0], G, R, S}
//   in_rm[2:0]             rounding mode (RNE, RTZ, RDN, RUP, RMM)
//   in_tag[TAG_W-1:0]      tag passed through unchanged
//   out_valid/out_ready    output handshake
//   out_data[31:0]         packed single-precision result
//   out_nx, out_of         inexact and overflow flags
//   out_tag[TAG_W-1:0]     tag of the result
module fpu_round_pack #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [34:0]      in_data,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_nx,
  output logic             out_of,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Stage 1 registers
  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [7:0]       r_s1_exp;
  logic [22:0]      r_s1_frac;
  logic             r_s1_nx;
  logic             r_s1_inc;
  logic             r_s1_zero;
  logic [2:0]       r_s1_rm;
  logic [TAG_W-1:0] r_s1_tag;

  // Stage 2 (output) registers
  logic             r_out_valid;
  logic [31:0]      r_out_data;
  logic             r_out_nx;
  logic             r_out_of;
  logic [TAG_W-1:0] r_out_tag;

  logic w_s2_adv;
  logic w_s1_adv;
  logic w_in_xfer;

  assign w_s2_adv  = ~r_out_valid | out_ready;
  assign w_s1_adv  = ~r_s1_valid | w_s2_adv;
  assign in_ready  = w_s1_adv & ~flush;
  assign w_in_xfer = in_valid & in_ready;

  // Stage 1: rounding decision from the guard/round/sticky bits
  logic w_g, w_r, w_s, w_lsb, w_sign, w_inexact, w_inc, w_zero;

  assign w_sign    = in_data[34];
  assign w_lsb     = in_data[3];
  assign w_g       = in_data[2];
  assign w_r       = in_data[1];
  assign w_s       = in_data[0];
  assign w_inexact = w_g | w_r | w_s;
  assign w_zero    = (in_data[33:3] == 31'd0) & ~w_inexact;

  always_comb begin
    w_inc = w_g & (w_r | w_s | w_lsb);  // RNE, also used for undefined codes
    case (in_rm)
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = w_sign & w_inexact;
      RM_RUP:  w_inc = ~w_sign & w_inexact;
      RM_RMM:  w_inc = w_g;
      default: w_inc = w_g & (w_r | w_s | w_lsb);
    endcase
  end

  // Stage 2: increment {exp,frac} as one field so a mantissa carry bumps exp
  logic [30:0] w_sum;
  logic        w_ovf;
  logic        w_to_inf;
  logic [31:0] w_res_data;
  logic        w_res_nx;
  logic        w_res_of;

  assign w_sum = {r_s1_exp, r_s1_frac} + {30'd0, r_s1_inc};
  assign w_ovf = (w_sum[30:23] == 8'hFF) | (r_s1_exp == 8'hFF);

  // Modes rounding away from the overflow direction saturate to max finite
  always_comb begin
    w_to_inf = 1'b1;
    case (r_s1_rm)
      RM_RTZ:  w_to_inf = 1'b0;
      RM_RDN:  w_to_inf = r_s1_sign;
      RM_RUP:  w_to_inf = ~r_s1_sign;
      default: w_to_inf = 1'b1;
    endcase
  end

  always_comb begin
    w_res_data = {r_s1_sign, w_sum};
    w_res_nx   = r_s1_nx;
    w_res_of   = 1'b0;
    if (r_s1_zero) begin
      w_res_data = {r_s1_sign, 31'd0};
      w_res_nx   = 1'b0;
    end else if (w_ovf) begin
      w_res_data = w_to_inf ? {r_s1_sign, 8'hFF, 23'd0} : {r_s1_sign, 8'hFE, 23'h7FFFFF};
      w_res_nx   = 1'b1;
      w_res_of   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= 8'd0;
      r_s1_frac   <= 23'd0;
      r_s1_nx     <= 1'b0;
      r_s1_inc    <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_rm     <= 3'd0;
      r_s1_tag    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_nx    <= 1'b0;
      r_out_of    <= 1'b0;
      r_out_tag   <= '0;
    end else if (flush) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_in_xfer;
        if (w_in_xfer) begin
          r_s1_sign <= w_sign;
          r_s1_exp  <= in_data[33:26];
          r_s1_frac <= in_data[25:3];
          r_s1_nx   <= w_inexact;
          r_s1_inc  <= w_inc;
          r_s1_zero <= w_zero;
          r_s1_rm   <= in_rm;
          r_s1_tag  <= in_tag;
        end
      end
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_res_data;
          r_out_nx   <= w_res_nx;
          r_out_of   <= w_res_of;
          r_out_tag  <= r_s1_tag;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_nx    = r_out_nx;
  assign out_of    = r_out_of;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_fpu_round_pack.sv
// tb/tb_fpu_round_pack.sv - self-checking testbench for fpu_round_pack
module tb_fpu_round_pack;

  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [34:0]      in_data;
  logic [2:0]       in_rm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_nx;
  logic             out_of;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {tag, of, nx, data}
  logic [39:0] sb[$];

  fpu_round_pack #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nx(out_nx), .out_of(out_of), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Reference rounding: returns {of, nx, data}
  function automatic logic [33:0] model(input logic [34:0] d, input logic [2:0] rm);
    logic s, g, r, st, inx, up, inf;
    logic [31:0] mag;
    s   = d[34];
    g   = d[2];
    r   = d[1];
    st  = d[0];
    inx = g | r | st;
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = s & inx;
      3'd3:    up = ~s & inx;
      3'd4:    up = g;
      default: up = g & (r | st | d[3]);
    endcase
    if (d[33:3] == 31'd0 && !inx) return {2'b00, s, 31'd0};
    mag = {1'b0, d[33:3]} + {31'd0, up};
    if (mag >= 32'h7F800000 || d[33:26] == 8'hFF) begin
      case (rm)
        3'd1:    inf = 1'b0;
        3'd2:    inf = s;
        3'd3:    inf = ~s;
        default: inf = 1'b1;
      endcase
      return {2'b11, s, inf ? 31'h7F800000 : 31'h7F7FFFFF};
    end
    return {1'b0, inx, s, mag[30:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_rm = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_nx, out_of, out_tag} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h nx=%b of=%b tag=%h want all 0",
               out_valid, out_data, out_nx, out_of, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_rounding();
    logic [71:0] v[$];   // {data35, rm3, of, nx, data32}
    logic [34:0] d;
    logic [2:0]  rm;
    logic [39:0] e;
    int idx = 0;
    int cyc = 0;
    v.push_back({1'b0, 8'd151, 23'h0,      3'b100, 3'd0, 2'b01, 32'h4B800000});
    v.push_back({1'b0, 8'd151, 23'h0,      3'b100, 3'd3, 2'b01, 32'h4B800001});
    v.push_back({1'b0, 8'd151, 23'h0,      3'b100, 3'd1, 2'b01, 32'h4B800000});
    v.push_back({1'b0, 8'd151, 23'h1,      3'b100, 3'd0, 2'b01, 32'h4B800002});
    v.push_back({1'b0, 8'd158, 23'h7FFFFF, 3'b111, 3'd0, 2'b01, 32'h4F800000});
    v.push_back({1'b0, 8'd254, 23'h7FFFFF, 3'b100, 3'd0, 2'b11, 32'h7F800000});
    v.push_back({1'b1, 8'd254, 23'h7FFFFF, 3'b100, 3'd3, 2'b01, 32'hFF7FFFFF});
    v.push_back({1'b1, 8'd127, 23'h0,      3'b000, 3'd0, 2'b00, 32'hBF800000});
    v.push_back({1'b1, 8'd254, 23'h7FFFFF, 3'b100, 3'd2, 2'b11, 32'hFF800000});
    v.push_back({1'b0, 8'd255, 23'h0,      3'b000, 3'd1, 2'b11, 32'h7F7FFFFF});
    v.push_back({1'b1, 8'd255, 23'h0,      3'b000, 3'd3, 2'b11, 32'hFF7FFFFF});
    v.push_back({1'b1, 8'd0,   23'h0,      3'b000, 3'd3, 2'b00, 32'h80000000});
    v.push_back({1'b0, 8'd151, 23'h1,      3'b100, 3'd7, 2'b01, 32'h4B800002});
    v.push_back({1'b0, 8'd151, 23'h0,      3'b100, 3'd4, 2'b01, 32'h4B800001});
    for (int i = 0; i < 60; i++) begin
      d  = {$urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)), 23'($urandom), 3'($urandom)};
      if (i % 7 == 0) d[33:3] = {8'd254, 23'h7FFFFF};
      if (i % 11 == 0) d[33:0] = '0;
      rm = 3'($urandom_range(0, 7));
      v.push_back({d, rm, model(d, rm)});
    end
    sb.delete();
    while ((idx < v.size() || sb.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      in_valid = (idx < v.size()) && ($urandom_range(0, 3) != 0);
      if (idx < v.size()) begin
        in_data = v[idx][71:37];
        in_rm   = v[idx][36:34];
        in_tag  = idx[5:0];
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL round_unexpected got tag=%h data=%h want no result", out_tag, out_data);
        end else begin
          e = sb.pop_front();
          if ({out_tag, out_of, out_nx, out_data} !== e) begin
            errors++;
            $display("FAIL round_result got tag=%h of=%b nx=%b data=%h want tag=%h of=%b nx=%b data=%h",
                     out_tag, out_of, out_nx, out_data, e[39:34], e[33], e[32], e[31:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({idx[5:0], v[idx][33:0]});
        idx++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL round_timeout got sent=%0d pending=%0d want all delivered", idx, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] e;
    logic [34:0] d;
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = {1'b0, 8'd130, 23'h123, 3'b011}; in_rm = 3'd0; in_tag = 6'd7;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready got %b want 1", in_ready); end
    sb.push_back({6'd7, model(in_data, in_rm)});
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early got %b want 0", out_valid); end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL lat_two got %b want 1", out_valid);
    end else begin
      e = sb.pop_front();
      if ({out_tag, out_of, out_nx, out_data} !== e) begin
        errors++; $display("FAIL lat_data got %h want %h", {out_tag, out_of, out_nx, out_data}, e);
      end
    end
    sb.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = (i < 8);
      d = {1'b0, 8'(100 + i), 23'($urandom), 3'($urandom)};
      in_data = d; in_rm = 3'(i % 5); in_tag = 6'(40 + i);
      #1;
      if (i < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready i=%0d got %b want 1", i, in_ready); end
      end
      if (i >= 2 && i < 10) begin
        checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
          errors++; $display("FAIL b2b_bubble i=%0d got out_valid=%b want 1", i, out_valid);
        end else begin
          e = sb.pop_front();
          if ({out_tag, out_of, out_nx, out_data} !== e) begin
            errors++; $display("FAIL b2b_data i=%0d got %h want %h", i, {out_tag, out_of, out_nx, out_data}, e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back({in_tag, model(d, in_rm)});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [39:0] exp_q[$];
    logic [39:0] e;
    logic [34:0] d;
    int got = 0;
    int cyc = 0;
    logic sent3 = 1'b0;
    sb.delete();
    out_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      d = {1'b0, 8'(120 + k), 23'(k * 1000), 3'b110};
      in_valid = 1'b1; in_data = d; in_rm = 3'd0; in_tag = 6'(k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d got %b want 1", k, in_ready); end
      sb.push_back({6'(k), model(d, 3'd0)});
    end
    exp_q = sb;
    @(negedge clk);
    d = {1'b1, 8'd123, 23'h3ABCDE, 3'b001};
    in_data = d; in_tag = 6'd3;
    for (int h = 0; h < 4; h++) begin
      if (h > 0) @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready h=%0d got %b want 0", h, in_ready); end
      checks++;
      if (out_valid !== 1'b1 || {out_tag, out_of, out_nx, out_data} !== exp_q[0]) begin
        errors++;
        $display("FAIL bp_hold h=%0d got v=%b %h want v=1 %h", h, out_valid, {out_tag, out_of, out_nx, out_data}, exp_q[0]);
      end
    end
    while ((!sent3 || sb.size() != 0) && cyc < 30) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'b1;
      if (sent3) in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        got++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_dup got tag=%h want no result", out_tag);
        end else begin
          e = sb.pop_front();
          if ({out_tag, out_of, out_nx, out_data} !== e) begin
            errors++; $display("FAIL bp_order got %h want %h", {out_tag, out_of, out_nx, out_data}, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({6'd3, model(d, 3'd0)});
        sent3 = 1'b1;
      end
    end
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra got tag=%h want no result", out_tag); end
    end
    checks++;
    if (got != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got); end
  endtask

  task automatic test_flush();
    logic [39:0] e;
    logic [34:0] d;
    int cyc = 0;
    sb.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = {1'b0, 8'(140 + k), 23'h55, 3'b010}; in_rm = 3'd0; in_tag = 6'(10 + k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_setup%0d got %b want 1", k, in_ready); end
    end
    @(negedge clk);
    flush = 1'b1; in_tag = 6'd12;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got %b want 0", out_valid); end
    repeat (4) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak got tag=%h want no result", out_tag); end
    end
    @(negedge clk);
    d = {1'b0, 8'd151, 23'h1, 3'b100};
    in_valid = 1'b1; in_data = d; in_rm = 3'd0; in_tag = 6'd13;
    #1;
    if (in_ready) sb.push_back({6'd13, model(d, 3'd0)});
    while (sb.size() != 0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      #1;
      if (out_valid) begin
        checks++;
        e = sb.pop_front();
        if ({out_tag, out_of, out_nx, out_data} !== e) begin
          errors++; $display("FAIL flush_after got %h want %h", {out_tag, out_of, out_nx, out_data}, e);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL flush_resume got pending=%0d want 0", sb.size()); end
  endtask

  task automatic test_midstream_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = {1'b1, 8'(135 + k), 23'h7777, 3'b101}; in_rm = 3'd3; in_tag = 6'(20 + k);
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0) begin
      errors++; $display("FAIL rst_mid got v=%b d=%h want v=0 d=00000000", out_valid, out_data);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_leak got tag=%h want no result", out_tag); end
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_round_pack.md
Name: fpu_round_pack

Overview:
- Downstream neighbour of the integer-to-float converter. Consumes its 35-bit unrounded float: {sign, exp[7:0], frac[22:0], guard, round, sticky}.
- Applies the IEEE-754 rounding mode and packs a 32-bit single-precision result with exception flags.
- Two-stage valid/ready pipeline. Carries a ROB tag through so results can be written back. Supports a flush for squashed instructions.

Parameters:
- TAG_W, 6, width of the tag carried alongside each operation.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill every in-flight operation; takes effect in the same cycle
- in_valid  in  1  input operation valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  35  [34] sign, [33:26] exp, [25:3] frac, [2] G, [1] R, [0] S
- in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
- in_tag  in  TAG_W  tag, passed through unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  32  IEEE single result
- out_nx  out  1  inexact flag
- out_of  out  1  overflow flag
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset: s1_valid=0, out_valid=0. out_data, out_nx, out_of and out_tag are all 0.
- Handshake:
  - Transfer occurs on valid&ready.
  - s2 advances when ~out_valid | out_ready.
  - s1 advances when ~s1_valid | s2 advances.
  - in_ready = s1 advances & ~flush.
  - Latency is 2 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 operation per cycle.
  - out_valid and out_data hold stable while out_valid & ~out_ready.
- Stage 1 (registered on input transfer) captures:
  - sign, exp, frac and tag
  - inexact = G|R|S
  - inc, decided by mode, with L = frac[0]:
    - RNE: G&(R|S|L)
    - RTZ: 0
    - RDN: sign&inexact
    - RUP: ~sign&inexact
    - RMM: G
    - codes 101/110/111: treated as RNE
  - a zero-input marker, set when exp==0 and frac==0 and G=R=S=0
- Stage 2 (registered on s1 advance):
  - {exp,frac} + inc, as a 31-bit add. A carry out of frac increments exp naturally; 0x7FFFFF+1 gives frac 0 and exp+1.
  - If the resulting exp==255, or input exp==255: overflow.
    - out_of=1 and out_nx=1.
    - The result is ±Inf (exp 255, frac 0) for RNE, RMM, RUP with positive sign, and RDN with negative sign.
    - Otherwise the result is signed max finite (exp 254, frac 0x7FFFFF).
  - Otherwise out_data = {sign, exp', frac'}, out_nx=inexact and out_of=0.
  - A zero input yields {sign,31'h0} with both flags 0.
- Flush:
  - Synchronous. Clears s1_valid and out_valid next cycle.
  - in_ready=0 during flush, so no input is accepted in the flush cycle.
  - flush has priority over every advance.
- Simultaneous out transfer and s1 advance in the same cycle: the new result replaces the old one with no bubble.
- Reset has priority over flush and clears the pipeline regardless of handshake state.
- Out-of-range exp (denormal inputs) does not occur from upstream. Exp 0 with nonzero frac is packed as-is, with no denormal handling.

Test Plan:
- 2^24+1 from upstream, {0, 8'd151, 23'h0, G=1, R=0, S=0}, with RNE -> 0x4B800000, nx=1. With RUP -> 0x4B800001, nx=1. With RTZ -> 0x4B800000, nx=1.
- 2^24+3, {0, 151, 23'h000001, G=1, R=0, S=0}, with RNE -> 0x4B800002, nx=1 (tie rounds to even).
- 0xFFFFFFFF unsigned, {0, 158, 23'h7FFFFF, 1, 1, 1}, with RNE -> carry into exp, giving 0x4F800000, nx=1, of=0.
- {0, 254, 23'h7FFFFF, 1, 0, 0}:
  - RNE -> 0x7F800000, of=1, nx=1.
  - Same value negative with RUP -> 0xFF7FFFFF, of=0, nx=1 (no increment).
  - Exact input {1, 8'd127, 0, 0, 0, 0} -> 0xBF800000, nx=0.
- Backpressure:
  - Stream tags 1,2,3 back-to-back with out_ready=0 after the first result. in_ready drops after 2 are buffered, and out_data/out_tag hold.
  - Releasing out_ready delivers tags 1,2,3 in order with no loss or duplication.
- Flush with two ops in flight -> out_valid=0 the next cycle, nothing from those ops appears, and in_ready=0 in the flush cycle.
- Assert rst mid-stream -> out_valid=0 and out_data=0 the next cycle.
